// File: rtl/pipe_adder.sv
// Pipelined unsigned adder: the carry chain is cut into NUM_REG slices, one per register stage.
// Optional macro PIPE_ADDER_STALL_EN adds an `en` input that freezes the whole pipeline when low.
module pipe_adder #(
  parameter int INP_DW  = 3,
  parameter int NUM_REG = 2
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef PIPE_ADDER_STALL_EN
  input  logic              en,
`endif
  input  logic [INP_DW-1:0] inp1,
  input  logic [INP_DW-1:0] inp2,
  input  logic              in_valid,
  output logic [INP_DW:0]   outp,
  output logic              out_valid
);

  // Slice width; trailing stages may own a short or empty slice and just forward the carry.
  localparam int W = (INP_DW + NUM_REG - 1) / NUM_REG;

  logic [INP_DW-1:0] r_a   [NUM_REG];
  logic [INP_DW-1:0] r_b   [NUM_REG];
  logic [INP_DW-1:0] r_sum [NUM_REG];
  logic              r_c   [NUM_REG];
  logic              r_v   [NUM_REG];

  logic [INP_DW-1:0] w_a_nxt   [NUM_REG];
  logic [INP_DW-1:0] w_b_nxt   [NUM_REG];
  logic [INP_DW-1:0] w_sum_nxt [NUM_REG];
  logic              w_c_nxt   [NUM_REG];
  logic              w_v_nxt   [NUM_REG];
  logic              w_adv;

`ifdef PIPE_ADDER_STALL_EN
  assign w_adv = en;
`else
  assign w_adv = 1'b1;
`endif

  always_comb begin
    logic              v_c;
    logic [INP_DW-1:0] v_a;
    logic [INP_DW-1:0] v_b;
    for (int k = 0; k < NUM_REG; k++) begin
      // Stage 0 reads the ports; later stages read the skewed operands and partial sum.
      v_a          = (k == 0) ? inp1     : r_a[(k == 0) ? 0 : k-1];
      v_b          = (k == 0) ? inp2     : r_b[(k == 0) ? 0 : k-1];
      v_c          = (k == 0) ? 1'b0     : r_c[(k == 0) ? 0 : k-1];
      w_v_nxt[k]   = (k == 0) ? in_valid : r_v[(k == 0) ? 0 : k-1];
      w_sum_nxt[k] = (k == 0) ? '0       : r_sum[(k == 0) ? 0 : k-1];
      w_a_nxt[k]   = v_a;
      w_b_nxt[k]   = v_b;
      for (int i = 0; i < INP_DW; i++) begin
        if (i >= k*W && i < (k+1)*W) begin
          w_sum_nxt[k][i] = v_a[i] ^ v_b[i] ^ v_c;
          v_c             = (v_a[i] & v_b[i]) | (v_c & (v_a[i] ^ v_b[i]));
        end
      end
      w_c_nxt[k] = v_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REG; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
        r_c[k]   <= 1'b0;
        r_v[k]   <= 1'b0;
      end
    end else if (w_adv) begin
      for (int k = 0; k < NUM_REG; k++) begin
        r_a[k]   <= w_a_nxt[k];
        r_b[k]   <= w_b_nxt[k];
        r_sum[k] <= w_sum_nxt[k];
        r_c[k]   <= w_c_nxt[k];
        r_v[k]   <= w_v_nxt[k];
      end
    end
  end

  assign outp      = {r_c[NUM_REG-1], r_sum[NUM_REG-1]};
  assign out_valid = r_v[NUM_REG-1];

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: three instances (latency 1, 2, 3) share one stimulus stream
// and are compared against a history-of-sums model indexed by enabled clock edges.
module tb_pipe_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] inp1 = '0;
  logic [2:0] inp2 = '0;
  logic       in_valid = 1'b0;
  logic       en = 1'b1;
  logic [3:0] outp1, outp2, outp3;
  logic       ov1, ov2, ov3;

  int hist_sum[$];
  bit hist_v[$];
  int reset_floor = 0;
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pipe_adder #(.INP_DW(3), .NUM_REG(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
`ifdef PIPE_ADDER_STALL_EN
    .en(en),
`endif
    .inp1(inp1), .inp2(inp2), .in_valid(in_valid), .outp(outp1), .out_valid(ov1));

  pipe_adder #(.INP_DW(3), .NUM_REG(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
`ifdef PIPE_ADDER_STALL_EN
    .en(en),
`endif
    .inp1(inp1), .inp2(inp2), .in_valid(in_valid), .outp(outp2), .out_valid(ov2));

  pipe_adder #(.INP_DW(3), .NUM_REG(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
`ifdef PIPE_ADDER_STALL_EN
    .en(en),
`endif
    .inp1(inp1), .inp2(inp2), .in_valid(in_valid), .outp(outp3), .out_valid(ov3));

  // Reference: the result seen after an enabled edge is the pair accepted L-1 enabled edges earlier.
  function automatic logic [3:0] model_outp(int lat);
    int idx = hist_sum.size() - lat;
    if (idx < reset_floor) return 4'd0;
    return 4'(hist_sum[idx]);
  endfunction

  function automatic logic model_valid(int lat);
    int idx = hist_sum.size() - lat;
    if (idx < reset_floor) return 1'b0;
    return hist_v[idx];
  endfunction

  // Driver: present a pair, let one edge take it, return on the following falling edge.
  task automatic cycle(input int a, input int b, input bit v);
    inp1     = 3'(a);
    inp2     = 3'(b);
    in_valid = v;
    @(posedge clk);
    if (en) begin
      hist_sum.push_back(a + b);
      hist_v.push_back(v);
    end
    @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    reset_floor = hist_sum.size();
  endtask

  task automatic test_reset();
    inp1 = 3'd7; inp2 = 3'd7; in_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_total++;
      if (outp2 !== 4'd0 || ov2 !== 1'b0)
        $display("FAIL reset_hold outp=%0d ov=%0b expected 0/0", outp2, ov2);
      else n_pass++;
    end
    release_reset();
    for (int c = 0; c < 3; c++) begin
      cycle(0, 0, 1'b0);
      n_total++;
      if (ov2 !== 1'b0 || outp2 !== model_outp(2))
        $display("FAIL reset_idle outp=%0d ov=%0b expected %0d/0", outp2, ov2, model_outp(2));
      else n_pass++;
    end
  endtask

  task automatic test_single();
    logic [3:0] exp_o[4] = '{4'd0, 4'd7, 4'd0, 4'd0};
    logic       exp_v[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int c = 0; c < 4; c++) begin
      if (c == 0) cycle(3, 4, 1'b1);
      else        cycle(0, 0, 1'b0);
      n_total++;
      if (ov2 !== exp_v[c] || (exp_v[c] && outp2 !== exp_o[c]))
        $display("FAIL single c=%0d outp=%0d ov=%0b expected %0d/%0b", c, outp2, ov2, exp_o[c], exp_v[c]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int         pa[4]  = '{7, 0, 1, 5};
    int         pb[4]  = '{7, 0, 3, 2};
    logic [3:0] exp[4] = '{4'd14, 4'd0, 4'd4, 4'd7};
    for (int c = 0; c < 6; c++) begin
      if (c < 4) cycle(pa[c], pb[c], 1'b1);
      else       cycle(0, 0, 1'b0);
      if (c >= 1 && c <= 4) begin
        n_total++;
        if (outp2 !== exp[c-1] || ov2 !== 1'b1)
          $display("FAIL b2b c=%0d outp=%0d ov=%0b expected %0d/1", c, outp2, ov2, exp[c-1]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_sweep();
    logic [3:0] got_o[3];
    logic       got_v[3];
    for (int n = 0; n < 64 + 3; n++) begin
      if (n < 64) cycle(n / 8, n % 8, 1'b1);
      else        cycle(0, 0, 1'b0);
      got_o = '{outp1, outp2, outp3};
      got_v = '{ov1, ov2, ov3};
      for (int l = 1; l <= 3; l++) begin
        n_total++;
        if (got_o[l-1] !== model_outp(l) || got_v[l-1] !== model_valid(l))
          $display("FAIL sweep lat=%0d n=%0d outp=%0d ov=%0b expected %0d/%0b",
                   l, n, got_o[l-1], got_v[l-1], model_outp(l), model_valid(l));
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] got_o[3];
    logic       got_v[3];
    for (int n = 0; n < 120; n++) begin
      cycle($urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
      got_o = '{outp1, outp2, outp3};
      got_v = '{ov1, ov2, ov3};
      for (int l = 1; l <= 3; l++) begin
        n_total++;
        if (got_o[l-1] !== model_outp(l) || got_v[l-1] !== model_valid(l))
          $display("FAIL random lat=%0d n=%0d outp=%0d ov=%0b expected %0d/%0b",
                   l, n, got_o[l-1], got_v[l-1], model_outp(l), model_valid(l));
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_midstream();
    cycle(1, 2, 1'b1);
    cycle(7, 6, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (outp1 !== 4'd0 || outp2 !== 4'd0 || outp3 !== 4'd0 || ov1 !== 1'b0 || ov2 !== 1'b0 || ov3 !== 1'b0)
      $display("FAIL async_reset outp=%0d/%0d/%0d ov=%0b%0b%0b expected all zero",
               outp1, outp2, outp3, ov1, ov2, ov3);
    else n_pass++;
    release_reset();
    for (int c = 0; c < 4; c++) begin
      cycle($urandom_range(0, 7), $urandom_range(0, 7), 1'b0);
      n_total++;
      if (ov1 !== 1'b0 || ov2 !== 1'b0 || ov3 !== 1'b0 || outp3 !== model_outp(3))
        $display("FAIL post_reset c=%0d ov=%0b%0b%0b outp3=%0d expected ov=000 outp3=%0d",
                 c, ov1, ov2, ov3, outp3, model_outp(3));
      else n_pass++;
    end
  endtask

`ifdef PIPE_ADDER_STALL_EN
  task automatic test_stall();
    logic [3:0] held_o;
    logic       held_v;
    cycle(6, 5, 1'b1);
    held_o = model_outp(2);
    held_v = model_valid(2);
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cycle($urandom_range(0, 7), $urandom_range(0, 7), 1'b1);
      n_total++;
      if (outp2 !== held_o || ov2 !== held_v)
        $display("FAIL stall_hold c=%0d outp=%0d ov=%0b expected %0d/%0b", c, outp2, ov2, held_o, held_v);
      else n_pass++;
    end
    en = 1'b1;
    cycle(0, 0, 1'b0);
    n_total++;
    if (outp2 !== 4'd11 || ov2 !== 1'b1)
      $display("FAIL stall_resume outp=%0d ov=%0b expected 11/1", outp2, ov2);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_sweep();
    test_random();
    test_reset_midstream();
`ifdef PIPE_ADDER_STALL_EN
    test_stall();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
